// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter
// Round-robin write arbiter and strobe sequencer for one shared PIPO byte
// register. Each write is a fixed four-cycle sequence: the winner's data is
// captured, held for a setup cycle, strobed for one cycle, and held for one
// more cycle while the requester is granted.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   req       per-requester write request (level, held until granted)
//   wdata     per-requester data, slice i = wdata[i*DW +: DW]
//   gnt       one-hot, 1-cycle grant pulse completing a write
//   pipo_d    registered data to the PIPO register input
//   pipo_che  registered load strobe to the PIPO register
//   busy      high while a write sequence is in progress
//   last_id   index of the most recently completed write
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | arbitrate; capture winner's data and index on a request
// SETUP  | pipo_d stable, strobe low
// STROBE | strobe high for one cycle, register loads on its edge
// HOLD   | strobe low, data held, grant pulse, advance pointer

module pipo_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       pipo_d,
  output logic                pipo_che,
  output logic                busy,
  output logic [ID_W-1:0]     last_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] nxt_ptr;

  // First set request at or after ptr, wrapping from N_REQ-1 back to 0.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // The just-served requester becomes lowest priority next time.
  assign nxt_ptr = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cur_id   <= '0;
      gnt      <= '0;
      pipo_d   <= '0;
      pipo_che <= 1'b0;
      last_id  <= '0;
    end else begin
      // Strobe and grant are single-cycle pulses, low unless the state sets them.
      gnt      <= '0;
      pipo_che <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            pipo_d <= wdata[win_id*DW +: DW];
            cur_id <= win_id;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          pipo_che <= 1'b1;
          state    <= S_STROBE;
        end
        S_STROBE: begin
          gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << cur_id;
          state <= S_HOLD;
        end
        S_HOLD: begin
          last_id <= cur_id;
          ptr     <= nxt_ptr;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Testbench for pipo_rr_arbiter: directed scenarios plus random traffic,
// checked by a scoreboard fed from a transaction-level reference model.
module tb_pipo_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [DW-1:0]  pipo_d;
  logic           pipo_che;
  logic           busy;
  logic [IDW-1:0] last_id;

  pipo_rr_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
    .pipo_d(pipo_d), .pipo_che(pipo_che), .busy(busy), .last_id(last_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared register the strobe loads.
  logic [DW-1:0] reg_q = '0;
  always @(posedge pipo_che) reg_q <= pipo_d;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    int            gc;   // cycle in which the grant is due
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            m_ptr = 0;
  int            m_cnt = 0;     // remaining busy cycles of the model's write
  int            exp_last = 0;
  bit            in_reset = 1'b1;
  logic [DW-1:0] wd[N];
  logic [N-1:0]  hold_req = '0;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one write takes four cycles; when free, the first
  // requester at or after the pointer wins and the pointer moves past it.
  task automatic model_step();
    int w;
    int i;
    if (m_cnt == 0) begin
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (w < 0 && req[i]) w = i;
        end
        q.push_back('{w, wd[w], cyc + 3});
        m_ptr = (w + 1) % N;
        m_cnt = 3;
      end
    end else begin
      m_cnt--;
    end
  endtask

  // One cycle of requester behaviour: drop granted requests, add new ones,
  // remove withdrawn ones, then let the model see the same inputs.
  task automatic tick(input logic [N-1:0] raise, input logic [N-1:0] drop, input bit rnd);
    @(negedge clk);
    #1;
    if (rnd) for (int k = 0; k < N; k++) wd[k] = DW'($urandom);
    hold_req = ((hold_req & ~gnt) | raise) & ~drop;
    req = hold_req;
    for (int k = 0; k < N; k++) wdata[k*DW +: DW] = wd[k];
    model_step();
  endtask

  task automatic drain(input int n);
    repeat (n) tick('0, '0, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the head of the scoreboard.
  always @(negedge clk) begin
    if (!in_reset) begin
      chk("busy", int'(busy), int'(m_cnt != 0));
      chk("last_id", int'(last_id), exp_last);
      if (q.size() != 0 && cyc == q[0].gc - 2)
        chk("pipo_d_setup", int'(pipo_d), int'(q[0].d));
      if (pipo_che) begin
        if (q.size() == 0) chk("che_unexpected", 1, 0);
        else begin
          chk("che_cycle", cyc, q[0].gc - 1);
          chk("pipo_d_at_che", int'(pipo_d), int'(q[0].d));
        end
      end
      if (gnt != '0) begin
        if (q.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
        else begin
          mon_e = q.pop_front();
          chk("gnt_id", int'(gnt), 1 << mon_e.id);
          chk("gnt_cycle", cyc, mon_e.gc);
          chk("reg_value", int'(reg_q), int'(mon_e.d));
          chk("pipo_d_hold", int'(pipo_d), int'(mon_e.d));
          exp_last = mon_e.id;
        end
      end else if (q.size() != 0 && cyc > q[0].gc) begin
        chk("gnt_timeout", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) wd[k] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_pipo_d", int'(pipo_d), 0);
    chk("rst_che", int'(pipo_che), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_last_id", int'(last_id), 0);
    #1;
    rst = 1'b0;
    in_reset = 1'b0;

    // All four held: grants 0,1,2,3,0
    wd[0] = 8'h10; wd[1] = 8'h21; wd[2] = 8'h32; wd[3] = 8'h43;
    repeat (20) tick(4'b1111, '0, 1'b0);
    tick('0, 4'b1111, 1'b0);
    drain(6);

    // Single request
    wd[1] = 8'hA5;
    tick(4'b0010, '0, 1'b0);
    drain(6);

    // Pointer wrap: grant 3, then 0 ahead of 3
    wd[3] = 8'h3C;
    tick(4'b1000, '0, 1'b0);
    drain(5);
    wd[0] = 8'h0F; wd[3] = 8'hF0;
    tick(4'b1001, '0, 1'b0);
    drain(10);

    // Withdrawal while busy, then withdrawal after selection
    wd[0] = 8'h55; wd[2] = 8'h66;
    tick(4'b0001, '0, 1'b0);
    tick(4'b0100, '0, 1'b0);
    tick('0, 4'b0100, 1'b0);
    drain(5);
    wd[2] = 8'h99;
    tick(4'b0100, '0, 1'b0);
    tick('0, 4'b0100, 1'b0);
    drain(5);

    // Same requester back-to-back
    wd[1] = 8'h12;
    repeat (10) tick(4'b0010, '0, 1'b0);
    tick('0, 4'b0010, 1'b0);
    drain(6);

    // Reset during STROBE after a grant to 0 moved the pointer to 1
    wd[0] = 8'h5C;
    tick(4'b0001, '0, 1'b0);
    drain(5);
    wd[2] = 8'h77;
    tick(4'b0100, '0, 1'b0);
    tick('0, '0, 1'b0);
    @(posedge clk);
    #2;
    chk("che_before_rst", int'(pipo_che), 1);
    rst = 1'b1;
    in_reset = 1'b1;
    #1;
    chk("abort_che", int'(pipo_che), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_pipo_d", int'(pipo_d), 0);
    chk("abort_last_id", int'(last_id), 0);
    q.delete();
    m_ptr = 0; m_cnt = 0; exp_last = 0;
    hold_req = '0; req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    in_reset = 1'b0;
    // Pointer restarts at 0: index 0 is served before index 3
    wd[0] = 8'h3A; wd[3] = 8'hC3;
    tick(4'b1001, '0, 1'b0);
    drain(10);

    // Random traffic with data changing every cycle
    for (int n = 0; n < 400; n++)
      tick(N'($urandom) & N'($urandom),
           ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, 1'b1);
    tick('0, 4'b1111, 1'b0);
    drain(8);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
